// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state and opcode-class
// encodings, MIPS-subset opcode values, ALU "add" selector and mux selects.
// The optional CTRL_ILLEGAL_TRAP_EN build uses the TRAP state defined here.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    FAULT    = 4'd12,
    TRAP     = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JMP, CLS_ILL
  } opclass_e;

  localparam int OP_RTYPE = 0;
  localparam int OP_BLTZ  = 1;
  localparam int OP_J     = 2;
  localparam int OP_JAL   = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_ADDI  = 8;
  localparam int OP_SLTI  = 10;
  localparam int OP_ANDI  = 12;
  localparam int OP_ORI   = 13;
  localparam int OP_LB    = 32;
  localparam int OP_LH    = 33;
  localparam int OP_LW    = 35;
  localparam int OP_SB    = 40;
  localparam int OP_SH    = 41;
  localparam int OP_SW    = 43;

  // Opcode-field value the ALU treats as a plain add (addi's encoding).
  localparam int ALU_ADD = OP_ADDI;

  localparam logic [1:0] MR_NONE = 2'b00;
  localparam logic [1:0] MR_BYTE = 2'b01;
  localparam logic [1:0] MR_HALF = 2'b10;
  localparam logic [1:0] MR_WORD = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  // States that hold mem_req and therefore count towards the memory timeout.
  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_opclass_decode.sv
// Combinational opcode classifier: maps the IR opcode field to an
// instruction class and, for loads, the access size driven on mem_read.
module ctrl_opclass_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  output opclass_e        op_class,
  output logic [1:0]      ld_size
);

  // Opcode lookup; anything not listed is illegal.
  always_comb begin
    op_class = CLS_ILL;
    ld_size  = MR_NONE;
    case (opcode)
      OP_W'(OP_RTYPE): op_class = CLS_R;
      OP_W'(OP_ADDI), OP_W'(OP_SLTI),
      OP_W'(OP_ANDI), OP_W'(OP_ORI): op_class = CLS_IMM;
      OP_W'(OP_LB): begin op_class = CLS_LOAD; ld_size = MR_BYTE; end
      OP_W'(OP_LH): begin op_class = CLS_LOAD; ld_size = MR_HALF; end
      OP_W'(OP_LW): begin op_class = CLS_LOAD; ld_size = MR_WORD; end
      OP_W'(OP_SB), OP_W'(OP_SH), OP_W'(OP_SW): op_class = CLS_STORE;
      OP_W'(OP_BLTZ), OP_W'(OP_BEQ), OP_W'(OP_BNE): op_class = CLS_BR;
      OP_W'(OP_J), OP_W'(OP_JAL): op_class = CLS_JMP;
      default: op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// mem_req/mem_ready handshake with a memory-wait timeout that latches fault.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = OP_W + 1,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               i_or_d,
  output logic [1:0]         mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               fault,
  output logic [3:0]         state_dbg
);

  localparam logic [ALUOP_W-1:0] ALU_OP_ADD = {1'b1, OP_W'(ALU_ADD)};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  // Low from reset until the first edge after release; keeps outputs quiet
  // so FETCH behaviour starts on that edge rather than at release.
  logic             run_q, run_d;
  opclass_e         op_class;
  logic [1:0]       ld_size;
  logic             timeout_hit;

  ctrl_opclass_decode #(.OP_W(OP_W)) u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .ld_size  (ld_size)
  );

  // This cycle is the TIMEOUT-th consecutive wait with memory still not ready.
  assign timeout_hit = !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign fault       = fault_q;
  assign state_dbg   = state_q;

  // State, wait counter, sticky fault and run flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      run_q   <= run_d;
    end
  end

  // Next-state and Moore output decode; FETCH strobes gated by mem_ready.
  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    run_d         = 1'b1;
    cnt_d         = '0;
    mem_req       = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = MR_NONE;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = '0;
    reg_dst       = DST_RT;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;

    // Counter runs only while stalled in a memory state; any other cycle
    // clears it, so it is always zero on entry to a memory state.
    if (run_q && is_mem_state(state_q) && !mem_ready) cnt_d = cnt_q + CNT_W'(1);

    if (run_q) begin
      case (state_q)
        FETCH: begin
          mem_req   = 1'b1;
          mem_read  = MR_WORD;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_OP_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end else if (timeout_hit) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          alu_op    = ALU_OP_ADD;
          case (op_class)
            CLS_R:     state_d = EXEC_R;
            CLS_IMM:   state_d = EXEC_I;
            CLS_LOAD,
            CLS_STORE: state_d = MEM_ADDR;
            CLS_BR:    state_d = BRANCH;
            CLS_JMP:   state_d = JUMP;
            CLS_ILL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              state_d = TRAP;
              fault_d = 1'b1;
`else
              state_d = FETCH;
`endif
            end
            default:   state_d = FETCH;
          endcase
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          state_d   = WB_R;
        end
        WB_R: begin
          reg_dst   = DST_RD;
          reg_write = 1'b1;
          state_d   = FETCH;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = {1'b1, opcode};
          state_d   = WB_I;
        end
        WB_I: begin
          reg_write = 1'b1;
          state_d   = FETCH;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = {1'b1, opcode};
          state_d   = (op_class == CLS_LOAD)  ? MEM_RD :
                      (op_class == CLS_STORE) ? MEM_WR : FETCH;
        end
        MEM_RD: begin
          mem_req  = 1'b1;
          i_or_d   = 1'b1;
          mem_read = ld_size;
          if (mem_ready) state_d = WB_MEM;
          else if (timeout_hit) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
        WB_MEM: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          state_d    = FETCH;
        end
        MEM_WR: begin
          mem_req   = 1'b1;
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) state_d = FETCH;
          else if (timeout_hit) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = {1'b1, opcode};
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
          state_d       = FETCH;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCS_JUMP;
          if (opcode == OP_W'(OP_JAL)) begin
            reg_write = 1'b1;
            reg_dst   = DST_R31;
          end
          state_d = FETCH;
        end
        FAULT: state_d = FAULT;
`ifdef CTRL_ILLEGAL_TRAP_EN
        TRAP:  state_d = TRAP;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a per-instruction
// reference model expands each instruction into its expected cycle trace,
// which is replayed against the DUT with immediate assertions.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond;
  logic       alu_src_a, mem_to_reg, reg_write, fault;
  logic [1:0] mem_read, pc_source, alu_src_b, reg_dst;
  logic [6:0] alu_op;
  logic [3:0] state_dbg;

  multicycle_control_fsm #(.OP_W(6), .ALUOP_W(7), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .fault(fault), .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       i_or_d;
    logic [1:0] mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [6:0] alu_op;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       fault;
  } ctrl_t;

  typedef struct {
    logic         ready;
    logic [5:0]   op;
    ctrl_t        exp;
    logic [63:0]  tag;
  } step_t;

  localparam logic [6:0] ADD = 7'b100_1000;

  ctrl_t obs;
  assign obs = {mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                reg_write, fault};

  step_t q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input ctrl_t exp, input logic [63:0] tag, input logic [5:0] op);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %0s op=%0d: observed %h required %h", tag, op, obs, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic [5:0] op, input ctrl_t c,
                      input logic [63:0] tag);
    step_t s;
    s.ready = rdy; s.op = op; s.exp = c; s.tag = tag;
    q.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle trace of one instruction. fw/mw are wait cycles
  // before mem_ready for the fetch and data access; hang keeps the data
  // access unanswered until the timeout. stuck = only a reset recovers.
  task automatic model_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit hang, output bit stuck);
    ctrl_t c;
    logic  is_ld, is_st;
    stuck = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      c = '0; c.mem_req = 1; c.mem_read = 2'b11; c.alu_src_b = 2'b01; c.alu_op = ADD;
      if (i == fw) begin c.ir_write = 1; c.pc_write = 1; end
      push(i == fw, op, c, "fetch");
    end
    c = '0; c.alu_src_b = 2'b11; c.alu_op = ADD;
    push(rnd_bit(), op, c, "decode");
    is_ld = op inside {32, 33, 35};
    is_st = op inside {40, 41, 43};
    if (op == 0) begin
      c = '0; c.alu_src_a = 1; push(rnd_bit(), op, c, "exec_r");
      c = '0; c.reg_dst = 2'b01; c.reg_write = 1; push(rnd_bit(), op, c, "wb_r");
    end else if (op inside {8, 10, 12, 13}) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = {1'b1, op};
      push(rnd_bit(), op, c, "exec_i");
      c = '0; c.reg_write = 1; push(rnd_bit(), op, c, "wb_i");
    end else if (is_ld || is_st) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = {1'b1, op};
      push(rnd_bit(), op, c, "memaddr");
      c = '0; c.mem_req = 1; c.i_or_d = 1;
      if (is_ld) c.mem_read = (op == 32) ? 2'b01 : (op == 33) ? 2'b10 : 2'b11;
      else       c.mem_write = 1;
      if (hang) begin
        for (int i = 0; i < TIMEOUT; i++) push(1'b0, op, c, "memwait");
        c = '0; c.fault = 1;
        for (int i = 0; i < 3; i++) push(rnd_bit(), op, c, "fault");
        stuck = 1'b1;
      end else begin
        for (int i = 0; i <= mw; i++) push(i == mw, op, c, "memacc");
        if (is_ld) begin
          c = '0; c.mem_to_reg = 1; c.reg_write = 1; push(rnd_bit(), op, c, "wb_mem");
        end
      end
    end else if (op inside {1, 4, 5}) begin
      c = '0; c.alu_src_a = 1; c.alu_op = {1'b1, op}; c.pc_write_cond = 1;
      c.pc_source = 2'b01;
      push(rnd_bit(), op, c, "branch");
    end else if (op inside {2, 3}) begin
      c = '0; c.pc_write = 1; c.pc_source = 2'b10;
      if (op == 3) begin c.reg_write = 1; c.reg_dst = 2'b10; end
      push(rnd_bit(), op, c, "jump");
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      c = '0; c.fault = 1;
      for (int i = 0; i < 3; i++) push(rnd_bit(), op, c, "trap");
      stuck = 1'b1;
`endif
    end
  endtask

  // Replay up to n queued cycles: drive at the falling edge, sample 1ns later.
  task automatic run_steps(input int n);
    step_t s;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      s = q.pop_front();
      @(negedge clk);
      opcode = s.op;
      mem_ready = s.ready;
      #1;
      check(s.exp, s.tag, s.op);
    end
  endtask

  // Async reset pulse between edges; outputs must drop at once and stay
  // quiet until the first rising edge after release.
  task automatic do_reset();
    ctrl_t z;
    z = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check(z, "rst_low", opcode);
    mem_ready = 1'b1;
    #1 check(z, "rst_rdy", opcode);
    #1 rst_n = 1'b1;
    #2 check(z, "rst_rel", opcode);
  endtask

  task automatic do_instr(input logic [5:0] op, input int fw, input int mw, input bit hang);
    bit stuck;
    model_instr(op, fw, mw, hang, stuck);
    run_steps(1000);
    if (stuck) do_reset();
  endtask

  initial begin
    int ops[20] = '{0, 8, 10, 12, 13, 32, 33, 35, 40, 41, 43, 1, 4, 5, 2, 3, 9, 6, 63, 20};
    bit stuck;
    logic [5:0] op;
    int mw;

    do_reset();

    do_instr(6'd0, 0, 0, 1'b0);            // R-type, zero wait
    do_instr(6'd32, 0, 3, 1'b0);           // lb with 3 wait cycles
    do_instr(6'd3, 0, 0, 1'b0);            // jal
    do_instr(6'd9, 0, 0, 1'b0);            // illegal opcode
    do_instr(6'd43, 1, TIMEOUT - 1, 1'b0); // sw, ready exactly on last allowed cycle
    do_instr(6'd43, 0, 0, 1'b1);           // sw, memory never answers
    do_instr(6'd35, 0, TIMEOUT - 1, 1'b0); // lw at the limit

    // Abort mid-MEM_RD: fetch, decode, address, two wait cycles, then reset.
    model_instr(6'd33, 0, 6, 1'b0, stuck);
    run_steps(5);
    q.delete();
    do_reset();
    do_instr(6'd4, 0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      op = 6'(ops[$urandom_range(0, 19)]);
      mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT - 1))
                                       : int'($urandom_range(0, 3));
      do_instr(op, int'($urandom_range(0, 3)), mw, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised multicycle successor to the single-cycle main decoder.
- Sequences each MIPS-subset instruction over several clock cycles: FETCH, DECODE, EXEC/MEM, WRITEBACK.
- Drives datapath enables and muxes, and handshakes with a shared instruction/data memory through mem_req/mem_ready.
- Sits between the instruction register's opcode field and the datapath; a memory-wait timeout counter flags a hung memory.

Parameters:
- OP_W, 6: opcode width; opcode values below assume 6.
- ALUOP_W, OP_W+1: ALU op width; non-R encoding is {1'b1, opcode}, R-type is all-zero.
- TIMEOUT, 15: maximum mem_ready wait cycles before FAULT; must be ≥1.
- CNT_W, 4: wait counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  instruction bits [31:26] from the IR; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request; held until mem_ready
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  2  load size: 01 byte, 10 half, 11 word, 00 none
- mem_write  out  1  store strobe, valid with mem_req
- ir_write  out  1  IR load enable
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write gated by branch compare
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  ALUOP_W  ALU control
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  1  writeback from MDR
- reg_write  out  1  register file write enable
- fault  out  1  sticky memory-timeout flag
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (async, rst_n=0): state = FETCH, wait counter = 0, fault = 0. Every control output is 0 during reset. The first active edge after release enters FETCH behaviour.
- Outputs are Moore-decoded from state, except ir_write and pc_write in FETCH, which are qualified by mem_ready.
- FETCH:
  - Asserts mem_req=1, i_or_d=0, mem_read=11, alu_src_a=0, alu_src_b=01, alu_op={1,8} (add).
  - On mem_ready: ir_write=1, pc_write=1, pc_source=00, then go to DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op={1,8} (branch target into ALUOut). Next state by opcode:
  - 0 → EXEC_R
  - 8, 10, 12, 13 → EXEC_I
  - 32, 33, 35, 40, 41, 43 → MEM_ADDR
  - 1, 4, 5 → BRANCH
  - 2, 3 → JUMP
  - anything else → FETCH (NOP)
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=0. Then WB_R.
- WB_R: reg_dst=01, reg_write=1. Then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op={1,opcode}. Then WB_I.
- WB_I: reg_dst=00, reg_write=1. Then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op={1,opcode}. Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD: mem_req=1, i_or_d=1, mem_read = 01/10/11 for opcode 32/33/35. Waits for mem_ready, then WB_MEM.
- WB_MEM: mem_to_reg=1, reg_dst=00, reg_write=1. Then FETCH.
- MEM_WR: mem_req=1, i_or_d=1, mem_write=1. Waits for mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op={1,opcode}, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Opcode 3 (jal) also asserts reg_write=1 with reg_dst=10. Then FETCH.
- Latency with zero-wait memory, counted in cycles from FETCH entry:
  - R-type and immediate: 4
  - load: 5
  - store: 4
  - branch and jump: 3
- Wait counter: cleared on entry to any memory state. Increments each cycle the FSM is in a memory state with mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready still 0: go to FAULT and set fault=1.
  - mem_ready on the same cycle the count hits TIMEOUT wins: normal transition, no fault.
- FAULT: all strobes 0, fault=1. Left only by reset.
- Reset asserted mid-instruction aborts immediately; no partial writeback completes.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE goes to TRAP. TRAP holds all strobes at 0 and asserts fault=1 (sticky until reset). state_dbg shows the TRAP code.
- Undefined: an unsupported opcode returns to FETCH as a NOP, and the TRAP state is not synthesised.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, FAULT, TRAP)
  - opcode constants (OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_LW=35, OP_SW=43, ...)
  - ALU_ADD constant and mux-select constants
- One sub-module, ctrl_opclass_decode: combinational opcode → class (R, IMM, LOAD, STORE, BR, JMP, ILL) plus load size.

Test Plan:
- R-type: opcode=0, mem_ready=1 always → states FETCH, DECODE, EXEC_R, WB_R. reg_write=1 with reg_dst=01 in cycle 4 only; back in FETCH at cycle 5.
- lb with wait: opcode=32, MEM_RD mem_ready low 3 cycles → mem_read=01 and i_or_d=1 held 4 cycles. WB_MEM has mem_to_reg=1; fault stays 0.
- jal: opcode=3 → JUMP cycle has pc_write=1, pc_source=10, reg_write=1, reg_dst=10; total 3 cycles.
- Timeout: sw (43) with mem_ready held 0, TIMEOUT=15 → after 15 wait cycles, state=FAULT, fault=1, mem_req=0. A repeat with mem_ready=1 exactly on the 15th cycle → no fault.
- Illegal opcode 9: macro undefined → FETCH follows DECODE, no strobes. Macro defined → TRAP, fault=1 until rst_n low.
- Async reset: rst_n pulsed low mid-MEM_RD between clock edges → all outputs 0 immediately; FETCH on the first edge after release.
